// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response channel,
// redirect from the control unit, and the instruction handoff to decode.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_target, instr_ready
  );

  // Memory / control / decode side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_target, instr_ready
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request FSM feeding a small
// instruction buffer toward decode, with redirect (taken branch/jump) that
// flushes the buffer and drops any response still in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [31:0]      PC0     = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state;
  logic               req;
  logic               discard;
  logic [31:0]        fetch_pc;
  logic [31:0]        pend_pc;
  logic [31:0]        target;
  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               not_empty;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign target    = {bus.redirect_target[31:2], 2'b00};
  assign not_empty = (count != '0);
  // Redirect wins over both ends of the buffer: the flush makes them moot.
  assign push      = (state == WAIT) && bus.imem_rvalid && !discard && !bus.redirect;
  assign pop       = not_empty && bus.instr_ready && !bus.redirect;

  // Buffer occupancy after this cycle's push, pop and flush.
  always_comb begin
    count_next = count;
    if (bus.redirect) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // Fetch FSM: issues one request at a time, only when the buffer will have room.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      discard  <= 1'b0;
      fetch_pc <= PC0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= target;
          end else if (count_next < DEPTH_C) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.imem_gnt) begin
            pend_pc <= fetch_pc;
            state   <= WAIT;
            req     <= 1'b0;
            if (bus.redirect) begin
              fetch_pc <= target;
              discard  <= 1'b1;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
            end
          end else if (bus.redirect) begin
            fetch_pc <= target;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            fetch_pc <= target;
          end
          if (bus.imem_rvalid) begin
            // A response coinciding with a redirect is dropped right here.
            discard <= 1'b0;
            if (count_next < DEPTH_C) begin
              state <= REQ;
              req   <= 1'b1;
            end else begin
              state <= IDLE;
              req   <= 1'b0;
            end
          end else if (bus.redirect) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  // Buffer storage: pc of the granted request paired with its returned word.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pend_pc;
      fifo_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req       = req;
  assign bus.imem_addr      = fetch_pc;
  assign bus.instr_valid    = not_empty;
  assign bus.instr          = not_empty ? fifo_instr[rd_ptr] : NOP;
  assign bus.instr_pc       = not_empty ? fifo_pc[rd_ptr] : 32'h0;
  assign bus.instr_pc_plus4 = not_empty ? fifo_pc[rd_ptr] + 32'd4 : 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scripted cycle scenarios plus a
// scoreboard of expected fetched pcs checked at every accepted instruction.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage_if bus2 ();

  if_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  if_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ {16'h0, a[31:16]};
  endfunction

  // Memory model for the main instance: grant gated by gnt_en, data one cycle later.
  logic gnt_en, hold_resp, pending;
  logic [31:0] pend_addr;
  assign bus.imem_gnt = bus.imem_req && gnt_en;
  always @(negedge clk) if (bus.imem_req && bus.imem_gnt) begin pending = 1'b1; pend_addr = bus.imem_addr; end
  always @(posedge clk) begin
    #2;
    bus.imem_rvalid = 1'b0;
    if (pending && !hold_resp) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
      pending = 1'b0;
    end
  end

  // Zero-wait memory for the wrap-around instance.
  logic pending2;
  logic [31:0] pend_addr2;
  assign bus2.imem_gnt = bus2.imem_req;
  always @(negedge clk) if (bus2.imem_req) begin pending2 = 1'b1; pend_addr2 = bus2.imem_addr; end
  always @(posedge clk) begin
    #2;
    bus2.imem_rvalid = 1'b0;
    if (pending2) begin
      bus2.imem_rvalid = 1'b1;
      bus2.imem_rdata  = mem_word(pend_addr2);
      pending2 = 1'b0;
    end
  end

  // Scoreboard: every instruction accepted by decode must be the next expected pc.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, required no instruction", bus.instr_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (bus.instr_pc !== e || bus.instr !== mem_word(e) || bus.instr_pc_plus4 !== e + 32'd4) begin
          n_fail++;
          $display("FAIL sb_instr: got pc %h instr %h pc4 %h, required pc %h instr %h pc4 %h",
                   bus.instr_pc, bus.instr, bus.instr_pc_plus4, e, mem_word(e), e + 32'd4);
        end
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; bus.instr_ready = 1'b0; bus.redirect = 1'b0; gnt_en = 1'b0; hold_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pending = 1'b0;
    sb.delete();
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h required 0", bus.imem_addr); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", bus.instr_valid); end
    n_cmp++; if (bus.instr !== 32'h13 || bus.instr_pc !== 32'h0 || bus.instr_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL rst_outs: got %h/%h/%h required 00000013/0/0", bus.instr, bus.instr_pc, bus.instr_pc_plus4); end
    n_cmp++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_addr_wrap: got %h required fffffffc", bus2.imem_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    logic [31:0] ea;
    do_reset();
    gnt_en = 1'b1; bus.instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) sb.push_back(32'(i * 4));
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== ((c >= 1) && (c % 2 == 1))) begin n_fail++; $display("FAIL stream_req c%0d: got %b", c, bus.imem_req); end
      if (c >= 1 && c % 2 == 1) begin
        ea = 32'((c - 1) / 2 * 4);
        n_cmp++; if (bus.imem_addr !== ea) begin n_fail++; $display("FAIL stream_addr c%0d: got %h required %h", c, bus.imem_addr, ea); end
      end
      n_cmp++; if (bus.instr_valid !== ((c >= 3) && (c % 2 == 1))) begin n_fail++; $display("FAIL stream_valid c%0d: got %b", c, bus.instr_valid); end
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    check_drained("stream");
  endtask

  task automatic test_backpressure;
    do_reset();
    gnt_en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) rst_n = 1'b1;
      @(negedge clk);
      if (c >= 6) begin
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req c%0d: got %b required 0", c, bus.imem_req); end
      end
      if (c == 10) begin
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
          n_fail++; $display("FAIL bp_head: got valid %b pc %h required 1 0", bus.instr_valid, bus.instr_pc); end
      end
      @(posedge clk); #1;
    end
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
    bus.instr_ready = 1'b1;
    for (int c = 11; c <= 16; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    check_drained("bp");
  endtask

  task automatic test_redirect_wait;
    do_reset();
    gnt_en = 1'b1; bus.instr_ready = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h100);
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) rst_n = 1'b1;
      if (c == 5) hold_resp = 1'b1;
      if (c == 6) begin bus.redirect = 1'b1; bus.redirect_target = 32'h100; end
      if (c == 7) begin bus.redirect = 1'b0; hold_resp = 1'b0; end
      @(negedge clk);
      if (c == 6) begin n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_wait_req: got %b required 0", bus.imem_req); end end
      if (c == 7 || c == 8) begin
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_empty c%0d: got %b required 0", c, bus.instr_valid); end
      end
      if (c == 8) begin
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
          n_fail++; $display("FAIL rw_newreq: got req %b addr %h required 1 00000100", bus.imem_req, bus.imem_addr); end
      end
      if (c == 10) begin n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rw_valid: got %b required 1", bus.instr_valid); end end
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    check_drained("rw");
  endtask

  task automatic test_gnt_stall;
    do_reset();
    bus.instr_ready = 1'b1;
    sb.push_back(32'h200);
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) rst_n = 1'b1;
      if (c == 3) begin bus.redirect = 1'b1; bus.redirect_target = 32'h203; end
      if (c == 4) bus.redirect = 1'b0;
      if (c == 7) gnt_en = 1'b1;
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
          n_fail++; $display("FAIL gs_hold c%0d: got req %b addr %h required 1 0", c, bus.imem_req, bus.imem_addr); end
      end
      if (c >= 4 && c <= 7) begin
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
          n_fail++; $display("FAIL gs_target c%0d: got req %b addr %h required 1 00000200", c, bus.imem_req, bus.imem_addr); end
      end
      if (c == 8) begin n_cmp++; if (bus.imem_addr !== 32'h204) begin n_fail++; $display("FAIL gs_advance: got %h required 00000204", bus.imem_addr); end end
      if (c == 9) begin n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL gs_valid: got %b required 1", bus.instr_valid); end end
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    check_drained("gs");
  endtask

  task automatic test_wrap;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) rst_n = 1'b1;
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) begin
          n_fail++; $display("FAIL wrap_req: got req %b addr %h required 1 fffffffc", bus2.imem_req, bus2.imem_addr); end
      end
      if (c == 3) begin
        n_cmp++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 32'hFFFF_FFFC || bus2.instr_pc_plus4 !== 32'h0
                     || bus2.instr !== mem_word(32'hFFFF_FFFC)) begin
          n_fail++; $display("FAIL wrap_first: got v %b pc %h pc4 %h instr %h required 1 fffffffc 0 %h",
                             bus2.instr_valid, bus2.instr_pc, bus2.instr_pc_plus4, bus2.instr, mem_word(32'hFFFF_FFFC)); end
      end
      if (c == 5) begin
        n_cmp++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 32'h0 || bus2.instr_pc_plus4 !== 32'h4) begin
          n_fail++; $display("FAIL wrap_second: got v %b pc %h pc4 %h required 1 0 4", bus2.instr_valid, bus2.instr_pc, bus2.instr_pc_plus4); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_redirect;
    do_reset();
    gnt_en = 1'b1;
    sb.push_back(32'h340);
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) rst_n = 1'b1;
      if (c == 8) begin bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_target = 32'h340; end
      if (c == 9) bus.redirect = 1'b0;
      @(negedge clk);
      if (c == 7) begin
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
          n_fail++; $display("FAIL fr_full: got valid %b req %b required 1 0", bus.instr_valid, bus.imem_req); end
      end
      if (c == 9) begin
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h13 || bus.instr_pc !== 32'h0 || bus.instr_pc_plus4 !== 32'h0) begin
          n_fail++; $display("FAIL fr_flush: got v %b instr %h pc %h pc4 %h required 0 00000013 0 0",
                             bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_pc_plus4); end
        n_cmp++; if (bus.imem_addr !== 32'h340) begin n_fail++; $display("FAIL fr_pc: got %h required 00000340", bus.imem_addr); end
      end
      if (c == 10) begin
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h340) begin
          n_fail++; $display("FAIL fr_req: got req %b addr %h required 1 00000340", bus.imem_req, bus.imem_addr); end
      end
      if (c == 12) begin n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL fr_valid: got %b required 1", bus.instr_valid); end end
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    check_drained("fr");
  endtask

  task automatic test_reset_mid;
    do_reset();
    gnt_en = 1'b1; bus.instr_ready = 1'b1;
    sb.push_back(32'h0);
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) rst_n = 1'b1;
      if (c == 2) begin rst_n = 1'b0; hold_resp = 1'b1; end
      if (c == 3) begin rst_n = 1'b1; hold_resp = 1'b0; end
      @(negedge clk);
      if (c == 3) begin
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL rm_reset: got req %b addr %h valid %b required 0 0 0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
      end
      if (c == 4) begin
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
          n_fail++; $display("FAIL rm_req: got req %b addr %h required 1 0", bus.imem_req, bus.imem_addr); end
      end
      if (c == 4 || c == 5) begin
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale c%0d: got %b required 0", c, bus.instr_valid); end
      end
      if (c == 6) begin n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rm_valid: got %b required 1", bus.instr_valid); end end
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b0;
    check_drained("rm");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; gnt_en = 1'b0; hold_resp = 1'b0; pending = 1'b0; pend_addr = '0;
    bus.redirect = 1'b0; bus.redirect_target = '0; bus.instr_ready = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    pending2 = 1'b0; pend_addr2 = '0;
    bus2.redirect = 1'b0; bus2.redirect_target = '0; bus2.instr_ready = 1'b1;
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_gnt_stall();
    test_wrap();
    test_full_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 2, the instruction buffer depth; only 2 is required to be supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  instruction-memory word address; bits [1:0] always 2'b00.
REQ-007 imem_gnt  input  1  request accepted in the current cycle.
REQ-008 imem_rvalid  input  1  read data valid; at most one response per granted request, in order.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect  input  1  taken branch or jump (PCSrc from the control unit).
REQ-011 redirect_target  input  32  new PC; bits [1:0] ignored and treated as 00.
REQ-012 instr_valid  output  1  instr, instr_pc and instr_pc_plus4 are valid toward decode.
REQ-013 instr_ready  input  1  decode accepts the instruction in the current cycle.
REQ-014 instr  output  32  instruction word to the decode/control stage.
REQ-015 instr_pc  output  32  PC of instr.
REQ-016 instr_pc_plus4  output  32  instr_pc + 4, modulo 2^32.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and WAIT; IDLE is entered on reset.
REQ-018 IDLE SHALL go to REQ one cycle after rst_n deasserts.
REQ-019 REQ: imem_req=1 and imem_addr=fetch_pc; on imem_gnt go to WAIT, else remain in REQ.
REQ-020 WAIT: imem_req=0; on imem_rvalid go to REQ if a buffer slot is free after this cycle's push and pop, else go to IDLE.
REQ-021 IDLE (post-reset): go to REQ as soon as a buffer slot is free.
REQ-022 At most one request SHALL be outstanding, and a request SHALL issue only if (buffer count + outstanding) < FIFO_DEPTH.
REQ-023 On grant, fetch_pc SHALL advance by 4; wrap-around from 32'hFFFF_FFFC to 0 SHALL be silent.
REQ-024 While imem_req=1 and no grant, imem_addr SHALL remain stable unless redirect is asserted.
REQ-025 A response without discard pending SHALL push {imem_addr_of_request, imem_rdata} into the FIFO.
REQ-026 instr_valid SHALL be 1 exactly when the FIFO is non-empty; outputs show the FIFO head.
REQ-027 The head SHALL pop when instr_valid && instr_ready.
REQ-028 A push and a pop in the same cycle SHALL both take effect.
REQ-029 When the FIFO is empty, instr SHALL be 32'h0000_0013 (NOP) and instr_pc and instr_pc_plus4 SHALL be 0.
REQ-030 Redirect SHALL, in the same edge, clear the FIFO, set fetch_pc to {redirect_target[31:2],2'b00}, and take priority over a simultaneous push or pop.
REQ-031 Redirect in WAIT, or in REQ together with imem_gnt, SHALL set discard; the next response is dropped, discard clears, and the FSM goes to REQ.
REQ-032 Redirect in REQ without imem_gnt SHALL keep imem_req=1 with imem_addr equal to the target from the next cycle.
REQ-033 Redirect in IDLE SHALL only update fetch_pc and empty the FIFO.
REQ-034 Steady-state throughput with a zero-wait memory (gnt same cycle, rvalid next cycle) SHALL be one instruction per 2 cycles.

Reset
REQ-035 While rst_n=0: state=IDLE, imem_req=0, imem_addr=RESET_PC, FIFO empty, discard=0, instr_valid=0, instr=32'h0000_0013.
REQ-036 Reset asserted mid-transaction SHALL abandon the outstanding request; a response arriving after reset SHALL be ignored while the FSM is not in WAIT.

Verification
REQ-037 Zero-wait memory, instr_ready=1: reset release at cycle 0 -> req addr 0x0 at cycle 1, instr_valid with pc 0x0 at cycle 3, then pcs 0x4, 0x8 every 2 cycles.
REQ-038 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered (pc 0x0, 0x4), imem_req=0, and no lost or duplicated pc when ready rises.
REQ-039 Redirect to 0x100 while in WAIT for pc 0x8 -> pc 0x8 response dropped, FIFO empty next cycle, next req addr 0x100, next valid instr_pc 0x100.
REQ-040 imem_gnt withheld 5 cycles -> imem_addr held stable throughout; redirect to 0x203 mid-stall -> imem_addr 0x200 from the next cycle.
REQ-041 Start from RESET_PC=32'hFFFF_FFFC -> pcs 0xFFFF_FFFC then 0x0, with instr_pc_plus4 of the first equal to 0x0.
REQ-042 Full FIFO + pop + redirect in the same cycle -> FIFO empty, instr_valid=0 next cycle, fetch_pc equals the target.
